// File: rtl/ofdm_qam_mapper.sv
// ofdm_qam_mapper: groups the serial interleaved bit stream into constellation
// symbols (BPSK/QPSK/16-QAM/64-QAM), Gray-maps each group to a Q1.6 I/Q point
// and tags it with its data-subcarrier index and OFDM-symbol number.
//
// Ports:
//   clock, reset      - rising-edge clock, asynchronous active-low reset
//   start, rate       - frame start pulse; rate[3:2] selects the modulation
//   tx_end            - frame end pulse, returns to idle
//   bit_in, bit_valid - serial input bit and its qualifier (gaps allowed)
//   i_out, q_out      - signed Q1.6 constellation point (64 = 1.0)
//   iq_valid          - one-cycle strobe for the point and its tags
//   sc_index          - data-subcarrier index 0..N_SC-1 of the point
//   sym_start         - strobe with iq_valid on subcarrier 0
//   sym_count         - OFDM symbol number of the point (0 = first after start)
//   busy              - frame in progress
module ofdm_qam_mapper #(
  parameter int unsigned HAS_SIGNAL = 1,
  parameter int unsigned N_SC       = 48
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        rate,
  input  logic              tx_end,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic signed [7:0] i_out,
  output logic signed [7:0] q_out,
  output logic              iq_valid,
  output logic [5:0]        sc_index,
  output logic              sym_start,
  output logic [10:0]       sym_count,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StSignal, StData} state_e;

  localparam logic [5:0] ScLast = 6'(N_SC - 1);

  state_e      state_q;
  logic [1:0]  mod_q;
  logic [2:0]  bit_cnt_q;
  logic [4:0]  shreg_q;
  logic [5:0]  sc_cnt_q;
  logic [10:0] sym_cnt_q;

  // Gray-coded 16-QAM axis level for a bit pair (first bit in the MSB).
  function automatic logic signed [7:0] map16(input logic [1:0] b);
    unique case (b)
      2'b00:   map16 = -8'sd61;
      2'b01:   map16 = -8'sd20;
      2'b11:   map16 = 8'sd20;
      default: map16 = 8'sd61;
    endcase
  endfunction

  // Gray-coded 64-QAM axis level for a bit triple (first bit in the MSB).
  function automatic logic signed [7:0] map64(input logic [2:0] b);
    unique case (b)
      3'b000:  map64 = -8'sd69;
      3'b001:  map64 = -8'sd49;
      3'b011:  map64 = -8'sd30;
      3'b010:  map64 = -8'sd10;
      3'b110:  map64 = 8'sd10;
      3'b111:  map64 = 8'sd30;
      3'b101:  map64 = 8'sd49;
      default: map64 = 8'sd69;
    endcase
  endfunction

  // The group as it will look once the current bit is shifted in; the first
  // received bit ends up in the most significant used position.
  logic [5:0]        grp;
  logic [1:0]        eff_mod;
  logic [2:0]        nbits;
  logic signed [7:0] i_map;
  logic signed [7:0] q_map;
  logic              last_bit;

  assign grp     = {shreg_q, bit_in};
  assign eff_mod = (state_q == StSignal) ? 2'b11 : mod_q;

  always_comb begin
    nbits = 3'd1;
    i_map = '0;
    q_map = '0;
    unique case (eff_mod)
      2'b11: begin
        nbits = 3'd1;
        i_map = grp[0] ? 8'sd64 : -8'sd64;
        q_map = '0;
      end
      2'b01: begin
        nbits = 3'd2;
        i_map = grp[1] ? 8'sd45 : -8'sd45;
        q_map = grp[0] ? 8'sd45 : -8'sd45;
      end
      2'b10: begin
        nbits = 3'd4;
        i_map = map16(grp[3:2]);
        q_map = map16(grp[1:0]);
      end
      default: begin
        nbits = 3'd6;
        i_map = map64(grp[5:3]);
        q_map = map64(grp[2:0]);
      end
    endcase
  end

  assign last_bit = (bit_cnt_q == (nbits - 3'd1));
  assign busy     = (state_q != StIdle);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      mod_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      sc_cnt_q  <= '0;
      sym_cnt_q <= '0;
      i_out     <= '0;
      q_out     <= '0;
      iq_valid  <= 1'b0;
      sc_index  <= '0;
      sym_start <= 1'b0;
      sym_count <= '0;
    end else begin
      iq_valid  <= 1'b0;
      sym_start <= 1'b0;
      if (start) begin
        // A bit arriving with start is dropped; accumulation begins next cycle.
        state_q   <= (HAS_SIGNAL != 0) ? StSignal : StData;
        mod_q     <= rate[3:2];
        bit_cnt_q <= '0;
        shreg_q   <= '0;
        sc_cnt_q  <= '0;
        sym_cnt_q <= '0;
      end else if (tx_end) begin
        state_q   <= StIdle;
        bit_cnt_q <= '0;
      end else if (state_q != StIdle && bit_valid) begin
        shreg_q <= grp[4:0];
        if (last_bit) begin
          bit_cnt_q <= '0;
          i_out     <= i_map;
          q_out     <= q_map;
          iq_valid  <= 1'b1;
          sym_start <= (sc_cnt_q == '0);
          sc_index  <= sc_cnt_q;
          sym_count <= sym_cnt_q;
          if (sc_cnt_q == ScLast) begin
            sc_cnt_q  <= '0;
            sym_cnt_q <= sym_cnt_q + 11'd1;
            if (state_q == StSignal) state_q <= StData;
          end else begin
            sc_cnt_q <= sc_cnt_q + 6'd1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: doc/ofdm_qam_mapper.md
# ofdm_qam_mapper

Downstream neighbour of the 802.11a PHY transmitter chain. It consumes the serial interleaved bit stream (transmitter `TX_OUT` / `TX_OUT_VALID`) and groups bits per the rate's modulation (BPSK/QPSK/16-QAM/64-QAM). It Gray-maps each group to a fixed-point I/Q constellation point and tags every point with its data-subcarrier index (0..47) and OFDM-symbol count. Its output feeds pilot insertion / IFFT framing.

## Interface
Parameters:
- `HAS_SIGNAL`, default 1: if 1, the first OFDM symbol after `start` is mapped BPSK (SIGNAL field), regardless of `rate`.
- `N_SC`, default 48: data subcarriers per OFDM symbol.

Ports:
- `clock`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state and outputs.
- `start`  in  1  one-cycle pulse; latches `rate` and begins a frame.
- `rate`  in  4  TXVECTOR rate code; sampled only when `start`=1.
- `tx_end`  in  1  one-cycle pulse; ends the frame and returns to IDLE.
- `bit_in`  in  1  serial interleaved bit.
- `bit_valid`  in  1  `bit_in` is valid this cycle; gaps are allowed.
- `i_out`  out  8  signed I, Q1.6 (64 = 1.0).
- `q_out`  out  8  signed Q, Q1.6.
- `iq_valid`  out  1  one-cycle strobe; `i_out`, `q_out`, `sc_index` and `sym_count` are valid.
- `sc_index`  out  6  data-subcarrier index of the current point, 0..N_SC-1.
- `sym_start`  out  1  high with `iq_valid` when `sc_index`=0.
- `sym_count`  out  11  OFDM symbol number of the current point; 0 = first symbol after `start`.
- `busy`  out  1  state ≠ IDLE.

## Operation
Modulation decode from the latched `rate` (`rate[0]` is ignored):
- `rate[3:2]`=11: BPSK, 1 bit per point.
- 01: QPSK, 2 bits.
- 10: 16-QAM, 4 bits.
- 00: 64-QAM, 6 bits.

State machine:
- IDLE → SIGNAL on `start` if `HAS_SIGNAL`=1; IDLE → DATA on `start` if `HAS_SIGNAL`=0.
- SIGNAL → DATA after the point with `sc_index`=N_SC-1 is emitted.
- Any state → IDLE on `tx_end`.
- SIGNAL always uses BPSK; DATA uses the latched modulation.

Bit grouping:
- Bit b0 is the first received bit of a group.
- A group is collected in a shift register; the bit counter resets at each group boundary.
- I uses the first half of the group, Q the second half. In BPSK, I uses b0 and Q=0.

Gray mapping, Q1.6 values:
- BPSK b0: 0→-64, 1→+64.
- QPSK per axis: 0→-45, 1→+45.
- 16-QAM per axis pair: 00→-61, 01→-20, 11→+20, 10→+61.
- 64-QAM per axis triple: 000→-69, 001→-49, 011→-30, 010→-10, 110→+10, 111→+30, 101→+49, 100→+69.

Counters:
- `sc_index` increments after each `iq_valid` and wraps N_SC-1→0.
- `sym_count` increments on that wrap and wraps at 2047.
- `start` clears both counters and the bit counter.

Boundary rules:
- `bit_valid` in IDLE is ignored.
- `start` while busy restarts the frame: the partial group is discarded, the rate is re-latched, and the counters clear.
- `start` and `bit_valid` in the same cycle: the bit is discarded; accumulation begins the next cycle.
- `tx_end` and `bit_valid` in the same cycle: the bit is discarded, and any partial group is dropped with no output.
- `tx_end` and `start` in the same cycle: `start` wins.
- Reset mid-frame: immediate return to IDLE with all outputs cleared.

## Timing
- Reset values: `i_out`=0, `q_out`=0, `iq_valid`=0, `sc_index`=0, `sym_start`=0, `sym_count`=0, `busy`=0.
- Latency: `iq_valid` is asserted exactly 1 cycle after the cycle in which the last bit of a group is accepted.
- Outputs are registered and hold their value until the next `iq_valid`; only the strobes (`iq_valid`, `sym_start`) return to 0.
- `busy` rises 1 cycle after `start` and falls 1 cycle after `tx_end`.
- Throughput: up to 1 bit per cycle, with no backpressure.
- The mode change SIGNAL→DATA takes effect on the first bit after the 48th SIGNAL point is emitted.

## Test plan
- BPSK, HAS_SIGNAL=0, `rate`=1101, 48 contiguous bits alternating 1,0 → 48 strobes with I=+64,-64,…, Q=0; `sc_index` 0..47; `sym_start` on the first strobe only; each strobe 1 cycle after its bit.
- 64-QAM (`rate`=0011), bits 100 010 → I=+69, Q=-10, `sc_index`=0; bits 000 101 → I=-69, Q=+49, `sc_index`=1.
- HAS_SIGNAL=1, `rate`=1011 (16-QAM), 48+192 bits → first 48 points BPSK with `sym_count`=0; then 48 16-QAM points with `sym_count`=1; pattern 1010 → I=+61, Q=+61.
- QPSK with `bit_valid` toggling every other cycle → identical values to the contiguous run, each strobe 1 cycle after every 2nd accepted bit.
- `start` after 3 of 4 16-QAM bits → no strobe emitted, counters at 0; the next 4 bits produce a point with `sc_index`=0.
- `tx_end` mid-group, then `reset` low mid-frame → no partial point emitted; all outputs 0 and `busy`=0 immediately on reset.
